// File: rtl/deinterleaver_if.sv
// Block-in / bit-out handshake bundle for the deinterleaver.
// slave: the deinterleaver side. master: the producer/consumer side.
interface deinterleaver_if #(
    parameter int N = 128
) ();
    logic [N-1:0] par_in;
    logic         in_valid;
    logic         in_ready;
    logic         out_bit;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport slave (
        input  par_in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_bit,
        output out_valid,
        output out_last
    );

    modport master (
        output par_in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_bit,
        input  out_valid,
        input  out_last
    );
endinterface

// File: rtl/deinterleaver.sv
// Block deinterleaver: takes one ROWS*COLS interleaved block in parallel and
// streams it out serially in original order. A holding buffer keeps one
// pending block so consecutive blocks leave back-to-back without a bubble.
module deinterleaver #(
    parameter int COLS = 8,
    parameter int ROWS = 16
) (
    input  logic             clk,
    input  logic             reset,
    deinterleaver_if.slave   bus,
    output logic             busy
);
    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    sr_q, sr_d;
    logic [N-1:0]    hb_q, hb_d;
    logic            hb_full_q, hb_full_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [N-1:0]    depermuted;
    logic            accept;
    logic            xfer;
    logic            at_last;

    // Undo the interleave: original bit n sits at column-major position
    // (n / COLS) + (n % COLS) * ROWS of the incoming block.
    for (genvar g = 0; g < N; g++) begin : g_deperm
        assign depermuted[g] = bus.par_in[(g / COLS) + (g % COLS) * ROWS];
    end

    assign accept        = bus.in_valid & ~hb_full_q;
    assign at_last       = (state_q == SHIFT) && (cnt_q == CW'(N - 1));
    assign xfer          = (state_q == SHIFT) & bus.out_ready;

    assign bus.in_ready  = ~hb_full_q;
    assign bus.out_valid = (state_q == SHIFT);
    assign bus.out_bit   = sr_q[0];
    assign bus.out_last  = at_last;
    assign busy          = (state_q == SHIFT) | hb_full_q;

    // Next-state: shift, reload at end of block, park a new block in HB.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        state_d   = state_q;
        sr_d      = sr_q;
        hb_d      = hb_q;
        hb_full_d = hb_full_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = depermuted;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer && !at_last) begin
                    sr_d  = sr_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                end else if (xfer && hb_full_q) begin
                    sr_d      = hb_q;
                    hb_full_d = 1'b0;
                    cnt_d     = '0;
                end else if (xfer && accept) begin
                    // Arrives exactly as the last bit leaves: bypass HB.
                    sr_d  = depermuted;
                    cnt_d = '0;
                end else if (xfer) begin
                    // Shift the final bit out so an idle SR reads as zero.
                    sr_d    = sr_q >> 1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end

                if (accept && !(xfer && at_last)) begin
                    hb_d      = depermuted;
                    hb_full_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; the data stores are cleared too so a reset mid-block
    // leaves no stale bits on out_bit.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // pre-edge values regardless of statement order.
        if (!reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            hb_q      <= '0;
            hb_full_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            hb_q      <= hb_d;
            hb_full_q <= hb_full_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_deinterleaver.sv
// Directed bench for the deinterleaver: single-bit position vectors, an
// interleaver round trip, back-to-back streaming, random backpressure and a
// mid-block reset.
module tb_deinterleaver;
    localparam int COLS = 8;
    localparam int ROWS = 16;
    localparam int N    = ROWS * COLS;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    always #5 clk = ~clk;

    deinterleaver_if #(.N(N)) bus ();

    deinterleaver #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    typedef struct {
        int in_pos;   // set bit of par_in
        int exp_pos;  // serial index where the 1 must appear
    } vec_t;

    int checks   = 0;
    int failures = 0;

    bit rx_q[$];
    bit rl_q[$];
    int gap_cnt;
    bit ir_low_seen;
    int stall_err;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference interleaver: write original bits row by row, read column by column.
    function automatic logic [N-1:0] interleave(input logic [N-1:0] orig);
        logic [N-1:0] res;
        res = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                res[c * ROWS + r] = orig[r * COLS + c];
        return res;
    endfunction

    function automatic logic [N-1:0] rx_block(input int b);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = rx_q[b * N + i];
        return v;
    endfunction

    function automatic logic [N-1:0] rl_block(input int b);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = rl_q[b * N + i];
        return v;
    endfunction

    task automatic send(input logic [N-1:0] d);
        int w;
        @(negedge clk);
        bus.par_in   = d;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1", bus.in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Collect nbits transfers; out_ready is set at the negedge and held over
    // the following posedge, so a sample with valid & ready is a transfer.
    task automatic recv(input int nbits, input bit stall);
        int   got;
        int   cyc;
        bit   started;
        bit   was_stall;
        logic pb;
        logic pl;
        rx_q.delete();
        rl_q.delete();
        gap_cnt     = 0;
        ir_low_seen = 0;
        stall_err   = 0;
        got         = 0;
        cyc         = 0;
        started     = 0;
        was_stall   = 0;
        pb          = 1'b0;
        pl          = 1'b0;
        while (got < nbits && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (was_stall && (bus.out_bit !== pb || bus.out_last !== pl)) stall_err++;
            if (busy && !bus.in_ready) ir_low_seen = 1;
            bus.out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (bus.out_valid) started = 1;
            else if (started) gap_cnt++;
            was_stall = bus.out_valid && !bus.out_ready;
            pb = bus.out_bit;
            pl = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                rx_q.push_back(bus.out_bit);
                rl_q.push_back(bus.out_last);
                got++;
            end
        end
        if (got < nbits) begin
            checks++;
            failures++;
            $display("FAIL recv_timeout: got %0d bits, required %0d", got, nbits);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vec_t         vecs[7];
        logic [N-1:0] last_exp;
        logic [N-1:0] pat;
        logic [N-1:0] pat_b;
        logic [N-1:0] pat_c;
        logic [N-1:0] blk;

        vecs[0] = '{in_pos: 16,  exp_pos: 1};
        vecs[1] = '{in_pos: 1,   exp_pos: 8};
        vecs[2] = '{in_pos: 127, exp_pos: 127};
        vecs[3] = '{in_pos: 0,   exp_pos: 0};
        vecs[4] = '{in_pos: 8,   exp_pos: 64};
        vecs[5] = '{in_pos: 17,  exp_pos: 9};
        vecs[6] = '{in_pos: 32,  exp_pos: 2};

        last_exp        = '0;
        last_exp[N - 1] = 1'b1;

        reset         = 1'b0;
        bus.par_in    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", N'({bus.out_valid, bus.out_last, busy, bus.out_bit}), '0);
        reset = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", N'(bus.in_ready), N'(1));

        // Single-bit position vectors
        for (int i = 0; i < 7; i++) begin
            check($sformatf("idle_valid_%0d", i), N'(bus.out_valid), '0);
            send(N'(1) << vecs[i].in_pos);
            check($sformatf("latency_%0d", i), N'(bus.out_valid), N'(1));
            recv(N, 1'b0);
            check($sformatf("data_%0d", i), rx_block(0), N'(1) << vecs[i].exp_pos);
            check($sformatf("last_%0d", i), rl_block(0), last_exp);
        end
        check("idle_after_block", N'({bus.out_valid, busy}), '0);

        // Round trip through the reference interleaver
        pat = {$urandom, $urandom, $urandom, $urandom};
        send(interleave(pat));
        recv(N, 1'b0);
        check("round_trip", rx_block(0), pat);

        // Random backpressure, same pattern
        send(interleave(pat));
        recv(N, 1'b1);
        check("stall_data", rx_block(0), pat);
        check("stall_hold", N'(stall_err), '0);

        // Three blocks back-to-back
        pat_b = {$urandom, $urandom, $urandom, $urandom};
        pat_c = {$urandom, $urandom, $urandom, $urandom};
        fork
            begin
                send(interleave(pat));
                send(interleave(pat_b));
                send(interleave(pat_c));
            end
            recv(3 * N, 1'b0);
        join
        check("b2b_block0", rx_block(0), pat);
        check("b2b_block1", rx_block(1), pat_b);
        check("b2b_block2", rx_block(2), pat_c);
        check("b2b_last1", rl_block(1), last_exp);
        check("b2b_gaps", N'(gap_cnt), '0);
        check("b2b_in_ready_low", N'(ir_low_seen), N'(1));

        // Reset in the middle of a block
        send(interleave(pat));
        recv(50, 1'b0);
        check("pre_reset_prefix", rx_block(0) & ((N'(1) << 50) - 1), pat & ((N'(1) << 50) - 1));
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_outputs", N'({bus.out_valid, bus.out_last, busy, bus.out_bit}), '0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("in_ready_after_mid_reset", N'(bus.in_ready), N'(1));
        blk = pat_b ^ pat_c;
        send(interleave(blk));
        recv(N, 1'b0);
        check("post_reset_block", rx_block(0), blk);
        check("post_reset_last", rl_block(0), last_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
